apb_cmd_master: RTL and testbench



---
 rtl/apb_cmd_master.sv | 168 ++++++++++++++++
 tb/tb_apb_cmd_master.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_master.sv
// ---------------------------------------------------------------------------
// apb_cmd_master
//
// Purpose:
//   APB3 initiator. Turns a valid/ready command stream into single APB
//   transfers (SETUP then ACCESS). It returns exactly one response per
//   accepted command. PREADY wait states are supported. A programmable
//   wait-state timeout aborts a transfer to a slave that never answers.
//
// Parameters:
//   ADDR_WIDTH  width of PADDR / cmd_addr
//   DATA_WIDTH  width of PWDATA / PRDATA / command and response data
//   TIMEOUT     max ACCESS cycles per transfer (0..255), 0 disables timeout
//
// Ports:
//   PCLK, PRESETn                  clock, async active-low reset
//   cmd_valid/cmd_ready            command handshake (ready only in IDLE)
//   cmd_write/cmd_addr/cmd_wdata   command payload, sampled on accept
//   rsp_valid                      one-cycle response pulse
//   rsp_rdata/rsp_err/rsp_timeout  response payload
//   PADDR/PWDATA/PWRITE/PSEL/PENABLE  APB request outputs
//   PRDATA/PREADY/PSLVERR             APB completion inputs
// ---------------------------------------------------------------------------
module apb_cmd_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  output logic                  PWRITE,
  output logic                  PSEL,
  output logic                  PENABLE,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  // The abort fires on the last allowed ACCESS edge, i.e. when the wait
  // counter (cleared in SETUP) has reached TIMEOUT-1.
  localparam bit         TO_EN       = (TIMEOUT != 0);
  localparam int         TO_LAST_INT = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
  localparam logic [7:0] TO_LAST     = TO_LAST_INT[7:0];

  state_t                state_q,       state_d;
  logic [7:0]            wait_cnt_q,    wait_cnt_d;
  logic                  cmd_ready_q,   cmd_ready_d;
  logic [ADDR_WIDTH-1:0] paddr_q,       paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q,      pwdata_d;
  logic                  pwrite_q,      pwrite_d;
  logic                  rsp_valid_q,   rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q,   rsp_rdata_d;
  logic                  rsp_err_q,     rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic                  timeout_hit;

  assign timeout_hit = TO_EN && (wait_cnt_q == TO_LAST);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= ST_IDLE;
      wait_cnt_q    <= '0;
      cmd_ready_q   <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pwrite_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      cmd_ready_q   <= cmd_ready_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pwrite_q      <= pwrite_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pwrite_d      = pwrite_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      ST_IDLE: begin
        // cmd_ready_q (not the state) gates accept, so nothing is taken
        // before the first edge after reset release.
        if (cmd_valid && cmd_ready_q) begin
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          pwrite_d = cmd_write;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        wait_cnt_d = '0;
        state_d    = ST_ACCESS;
      end
      ST_ACCESS: begin
        // Completion is checked first so PREADY wins over a same-edge timeout.
        if (PREADY) begin
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
          rsp_err_d     = PSLVERR;
          rsp_timeout_d = 1'b0;
          state_d       = ST_IDLE;
        end else if (timeout_hit) begin
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registered ready: high exactly while the next state is IDLE.
    cmd_ready_d = (state_d == ST_IDLE);
  end

  // PSEL/PENABLE decode straight from the state register so that an
  // asynchronous reset drops them immediately.
  assign PSEL        = (state_q != ST_IDLE);
  assign PENABLE     = (state_q == ST_ACCESS);
  assign cmd_ready   = cmd_ready_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign PWRITE      = pwrite_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_apb_cmd_master
//
// Directed bench for apb_cmd_master built with TIMEOUT=4. A table of single
// transfers is driven through an APB slave model whose wait states, PSLVERR
// and PRDATA come from each record. Hand-written sequences cover reset,
// back-to-back throughput and reset in the middle of a transfer.
// Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_apb_cmd_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;
  localparam int NEVER = 255;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic          PWRITE;
  logic          PSEL;
  logic          PENABLE;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  apb_cmd_master #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT   (TO)
  ) dut (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .PADDR      (PADDR),
    .PWDATA     (PWDATA),
    .PWRITE     (PWRITE),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY),
    .PSLVERR    (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  // waits: ACCESS cycles with PREADY low before PREADY goes high (NEVER = stuck low)
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic        err_wait;
    logic        err_done;
    logic [31:0] prdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
    int          exp_acc;
    int          exp_lat;
  } vec_t;

  vec_t vecs[9];
  int   n_pass  = 0;
  int   n_total = 0;
  int   cur_vec = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s (vec %0d): got 0x%0h expected 0x%0h", name, cur_vec, act, exp);
    else
      n_pass++;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s (vec %0d): got %b expected %b", name, cur_vec, act, exp);
    else
      n_pass++;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int acc;
    int lat;
    bit got;
    cur_vec = idx;
    @(negedge PCLK);
    chk1("ready_before", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_write = v.wr;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    @(negedge PCLK);
    // Scramble the command inputs: only the accept edge may sample them.
    cmd_valid = 1'b0;
    cmd_write = ~v.wr;
    cmd_addr  = ~v.addr;
    cmd_wdata = ~v.wdata;
    chk1("setup_psel", PSEL, 1'b1);
    chk1("setup_penable", PENABLE, 1'b0);
    chk1("setup_ready", cmd_ready, 1'b0);
    chk("setup_paddr", PADDR, v.addr);
    chk("setup_pwdata", PWDATA, v.wdata);
    chk1("setup_pwrite", PWRITE, v.wr);
    acc = 0;
    lat = 1;
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge PCLK);
      lat++;
      if (PSEL && PENABLE) begin
        PREADY  = (acc == v.waits);
        PSLVERR = PREADY ? v.err_done : v.err_wait;
        PRDATA  = v.prdata;
        acc++;
        chk("access_paddr", PADDR, v.addr);
        chk1("access_pwrite", PWRITE, v.wr);
      end else begin
        got     = 1'b1;
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
      end
    end
    n_total++;
    if (got) n_pass++;
    else $display("FAIL rsp_bound (vec %0d): got no end of transfer expected one within 40 cycles", idx);
    $display("vec %0d: %s addr=0x%0h acc=%0d lat=%0d rdata=0x%0h err=%b to=%b",
             idx, v.wr ? "WR" : "RD", v.addr, acc, lat, rsp_rdata, rsp_err, rsp_timeout);
    chk1("rsp_valid", rsp_valid, 1'b1);
    chk("access_cycles", acc, v.exp_acc);
    chk("latency", lat, v.exp_lat);
    chk("rsp_rdata", rsp_rdata, v.exp_rdata);
    chk1("rsp_err", rsp_err, v.exp_err);
    chk1("rsp_timeout", rsp_timeout, v.exp_to);
    chk1("rsp_ready", cmd_ready, 1'b1);
    chk1("rsp_psel", PSEL, 1'b0);
    @(negedge PCLK);
    chk1("rsp_pulse", rsp_valid, 1'b0);
    chk("rsp_hold", rsp_rdata, v.exp_rdata);
  endtask

  initial begin : main
    logic [31:0] b2b_addr[4];
    int          acc_cyc[4];
    int          k;
    int          r;
    bit          prev_ready;
    bit          prev_setup;

    //                wr    addr          wdata          waits  ew    ed    prdata        exp_rdata     err   to   acc lat
    vecs[0] = '{1'b1, 32'h0000_0008, 32'h0000_0005,  0,   1'b0, 1'b0, 32'h0000_0077, 32'h0000_0000, 1'b0, 1'b0, 1, 3};
    vecs[1] = '{1'b0, 32'h0000_0010, 32'h0000_0000,  2,   1'b0, 1'b0, 32'h0000_DEAD, 32'h0000_DEAD, 1'b0, 1'b0, 3, 5};
    vecs[2] = '{1'b0, 32'h0000_0014, 32'h0000_0000,  0,   1'b0, 1'b1, 32'h0000_1234, 32'h0000_1234, 1'b1, 1'b0, 1, 3};
    vecs[3] = '{1'b0, 32'h0000_0018, 32'h0000_0000,  1,   1'b1, 1'b0, 32'h0000_BEEF, 32'h0000_BEEF, 1'b0, 1'b0, 2, 4};
    vecs[4] = '{1'b0, 32'h0000_001C, 32'h0000_0000, NEVER,1'b0, 1'b0, 32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b1, 4, 6};
    vecs[5] = '{1'b0, 32'h0000_0020, 32'h0000_0000,  3,   1'b0, 1'b0, 32'h0000_CAFE, 32'h0000_CAFE, 1'b0, 1'b0, 4, 6};
    vecs[6] = '{1'b1, 32'h0000_0024, 32'hA5A5_0001,  3,   1'b0, 1'b1, 32'h0000_5555, 32'h0000_0000, 1'b1, 1'b0, 4, 6};
    vecs[7] = '{1'b1, 32'h0000_0028, 32'h1234_5678, NEVER,1'b1, 1'b0, 32'h0000_1111, 32'h0000_0000, 1'b1, 1'b1, 4, 6};
    vecs[8] = '{1'b0, 32'h0000_002C, 32'h0000_0000,  0,   1'b1, 1'b0, 32'h8000_0001, 32'h8000_0001, 1'b0, 1'b0, 1, 3};

    PRESETn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    PRDATA    = 32'h0BAD_F00D;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;

    // Reset state: every output low, cmd_ready rises one edge after release.
    repeat (2) @(negedge PCLK);
    chk1("rst_ready", cmd_ready, 1'b0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk1("rst_psel", PSEL, 1'b0);
    chk1("rst_penable", PENABLE, 1'b0);
    chk("rst_paddr", PADDR, 32'h0);
    chk("rst_pwdata", PWDATA, 32'h0);
    chk1("rst_pwrite", PWRITE, 1'b0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk1("rst_err", rsp_err, 1'b0);
    chk1("rst_timeout", rsp_timeout, 1'b0);
    PRESETn = 1'b1;
    #1;
    chk1("rel_ready_before_edge", cmd_ready, 1'b0);
    @(negedge PCLK);
    chk1("rel_ready_after_edge", cmd_ready, 1'b1);
    $display("reset: ready=%b psel=%b", cmd_ready, PSEL);

    // Single-transfer table.
    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Back-to-back reads with cmd_valid held; slave answers {A5A5, PADDR[15:0]}.
    cur_vec    = 100;
    b2b_addr   = '{32'h0000_0100, 32'h0000_0204, 32'h0000_0308, 32'h0000_040C};
    acc_cyc    = '{0, 0, 0, 0};
    k          = 0;
    r          = 0;
    @(negedge PCLK);
    PREADY     = 1'b1;
    PSLVERR    = 1'b0;
    cmd_write  = 1'b0;
    cmd_addr   = b2b_addr[0];
    cmd_valid  = 1'b1;
    prev_ready = cmd_ready;
    prev_setup = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge PCLK);
      if (prev_ready && cmd_valid && k < 4) begin
        acc_cyc[k] = c;
        k++;
        if (k < 4) cmd_addr = b2b_addr[k];
        else       cmd_valid = 1'b0;
      end
      if (prev_setup) chk("b2b_setup_to_access", {30'd0, PSEL, PENABLE}, 32'h3);
      PRDATA = {16'hA5A5, PADDR[15:0]};
      if (rsp_valid) begin
        if (r < 4) begin
          chk("b2b_rdata", rsp_rdata, {16'hA5A5, b2b_addr[r][15:0]});
          $display("b2b rsp %0d: cycle=%0d rdata=0x%0h", r, c, rsp_rdata);
        end
        chk1("b2b_rsp_ready", cmd_ready, 1'b1);
        r++;
      end
      prev_ready = cmd_ready;
      prev_setup = PSEL && !PENABLE;
    end
    cmd_valid = 1'b0;
    PREADY    = 1'b0;
    chk("b2b_accepts", k, 4);
    chk("b2b_responses", r, 4);
    for (int i = 1; i < 4; i++) chk("b2b_gap", acc_cyc[i] - acc_cyc[i-1], 3);

    // Reset while the slave is stalling in ACCESS.
    cur_vec = 200;
    @(negedge PCLK);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0000_0300;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    chk("mid_in_access", {30'd0, PSEL, PENABLE}, 32'h3);
    #2;
    PRESETn = 1'b0;
    #1;
    chk1("mid_psel", PSEL, 1'b0);
    chk1("mid_penable", PENABLE, 1'b0);
    chk1("mid_ready", cmd_ready, 1'b0);
    chk1("mid_rsp_valid", rsp_valid, 1'b0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    #1;
    chk1("mid_rel_ready", cmd_ready, 1'b0);
    @(negedge PCLK);
    chk1("mid_ready_after", cmd_ready, 1'b1);
    chk1("mid_no_rsp", rsp_valid, 1'b0);
    $display("mid-reset: psel=%b ready=%b rsp_valid=%b", PSEL, cmd_ready, rsp_valid);
    run_vec(300, vecs[1]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
